// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter for N requesters: registered one-hot grant held while the owner keeps
// requesting, forced release after MAX_HOLD cycles when others wait. Optional macro ARB_LOCK_EN.
//   state | meaning
//   IDLE  | no owner, gnt = 0
//   OWN   | owner_q holds the resource, gnt = one-hot(owner_q)
module rr_arbiter_n #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           lock,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [0:0]    ST_IDLE = 1'b0;
  localparam logic [0:0]    ST_OWN  = 1'b1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   gnt_q, gnt_d;

  logic           lock_eff;
  logic [N-1:0]   owner_oh;
  logic [N-1:0]   others;
  logic [N-1:0]   cand;
  logic           keep;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] scan_idx;

  function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] v);
    if (v == IDW'(N - 1)) return '0;
    return v + 1'b1;
  endfunction

`ifdef ARB_LOCK_EN
  assign lock_eff = lock;
`else
  assign lock_eff = lock & 1'b0;
`endif

  assign owner_oh = N'(1) << owner_q;
  assign others   = req & ~owner_oh;
  // On release the old owner is masked so the handover never re-selects it.
  assign cand     = (state_q == ST_OWN) ? others : req;
  assign keep     = (state_q == ST_OWN) && req[owner_q] &&
                    ((cnt_q < CNT_MAX) || (others == '0) || lock_eff);

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = IDW'((int'(ptr_q) + i) % N);
      if (!win_found && cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    if (keep) begin
      if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (win_found) begin
      state_d = ST_OWN;
      owner_d = win_idx;
      ptr_d   = inc_mod(win_idx);
      cnt_d   = CNT_ONE;
      gnt_d   = N'(1) << win_idx;
    end else begin
      state_d = ST_IDLE;
      owner_d = '0;
      cnt_d   = '0;
      gnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = (state_q == ST_OWN);
  assign gnt_id    = owner_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Scoreboard bench for rr_arbiter_n (N=4, MAX_HOLD=4): directed scenarios plus random traffic
// checked against a behavioural round-robin model.
module tb_rr_arbiter_n;
  localparam int N    = 4;
  localparam int MAXH = 4;
  localparam int IDW  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic           lock = 1'b0;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;

  rr_arbiter_n #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   g;
    logic           v;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 = idle), rotating start pointer, consecutive-grant count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
    end
  endtask

  function automatic int search(input logic [N-1:0] r, input int start);
    for (int off = 0; off < N; off++) begin
      int i;
      i = (start + off) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic l);
    int w;
    bit lock_on;
    logic [N-1:0] rest;
`ifdef ARB_LOCK_EN
    lock_on = l;
`else
    lock_on = 1'b0;
`endif
    if (m_owner < 0) begin
      w = search(r, m_ptr);
      if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % N; m_cnt = 1; end
    end else begin
      rest = r;
      rest[m_owner] = 1'b0;
      if (r[m_owner] && (m_cnt < MAXH || rest == '0 || lock_on)) begin
        if (m_cnt < MAXH) m_cnt++;
      end else begin
        w = search(rest, m_ptr);
        if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % N; m_cnt = 1; end
        else begin m_owner = -1; m_cnt = 0; end
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.v  = (m_owner >= 0);
    e.g  = e.v ? (N'(1) << m_owner) : '0;
    e.id = e.v ? IDW'(m_owner) : '0;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [N-1:0] r, input logic l);
    @(negedge clk);
    req  = r;
    lock = l;
    model_step(r, l);
    push_exp();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset between edges, then release on the following falling edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", gnt_valid, 0);
    chk("rst_id", gnt_id, 0);
    req = '0; lock = 1'b0;
    m_owner = -1; m_ptr = 0; m_cnt = 0;
    push_exp();
    @(negedge clk);
    rst = 1'b1;
    model_step('0, 1'b0);
    push_exp();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_gnt", gnt, e.g);
        chk("sb_valid", gnt_valid, e.v);
        chk("sb_id", gnt_id, e.id);
        chk("onehot", ($countones(gnt) <= 1), 1);
      end
    end
  end

  initial begin : stim
    int ord[5];
    logic [N-1:0] r;
    logic [N-1:0] drop;
    logic l;
    ord = '{0, 1, 2, 3, 0};

    #1 rst = 1'b0;
    #3;
    chk("init_gnt", gnt, 0);
    chk("init_valid", gnt_valid, 0);
    chk("init_id", gnt_id, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_step('0, 1'b0);
    push_exp();

    // single request then release
    drive(4'b0100, 1'b0); settle();
    chk("single_gnt", gnt, 4'b0100);
    chk("single_id", gnt_id, 2);
    drive(4'b0000, 1'b0); settle();
    chk("single_drop", gnt, 4'b0000);

    // rotation with zero-bubble handover
    do_reset();
    drive(4'b1111, 1'b0); settle();
    chk("rot_id0", gnt_id, ord[0]);
    for (int i = 1; i < 5; i++) begin
      drop = 4'b1111 & ~(4'b0001 << ord[i-1]);
      drive(drop, 1'b0); settle();
      chk("rot_id", gnt_id, ord[i]);
      chk("rot_valid", gnt_valid, 1);
    end

    // forced release after MAX_HOLD
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(4'b0011, 1'b0); settle();
      chk("forced", gnt, (i < 4 || i >= 8) ? 4'b0001 : 4'b0010);
    end

    // sole requester holds past the limit, then yields at once
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(4'b1000, 1'b0); settle();
      chk("sole", gnt, 4'b1000);
    end
    drive(4'b1001, 1'b0); settle();
    chk("sole_yield", gnt, 4'b0001);

    // lock
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(4'b0011, 1'b1); settle();
`ifdef ARB_LOCK_EN
      chk("lock_hold", gnt, 4'b0001);
`else
      chk("lock_ign", gnt, (i < 4 || i >= 8) ? 4'b0001 : 4'b0010);
`endif
    end
    drive(4'b0011, 1'b0); settle();
`ifdef ARB_LOCK_EN
    chk("lock_fall", gnt, 4'b0010);
`else
    chk("lock_fall", gnt, 4'b0001);
`endif

    // async reset mid-grant
    do_reset();
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b0); settle();
    chk("mid_pre", gnt, 4'b0100);
    do_reset();
    drive(4'b1111, 1'b0); settle();
    chk("post_rst", gnt, 4'b0001);

    // random traffic with sticky requests
    r = '0; l = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 7) == 0) l = ~l;
      drive(r, l);
      if (c == 300) do_reset();
    end

    @(posedge clk);
    #3;
    chk("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
